life_compositor: RTL and testbench

LIFE_COMPOSITOR -- requirements
Module: life_compositor

---
 rtl/life_compositor_if.sv | 38 +++
 rtl/life_compositor.sv | 173 +++++++++++++++++
 tb/tb_life_compositor.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_compositor_if.sv
// Bundle for life_compositor: object release, player state and the registered game outputs.
// Latency: none. This file only groups wires.
// Backpressure: none. Every signal is a level that is sampled once per frame.
// Ports:
//   RELEASE_BARRIER/RELEASE_COIN [1:0] lane code from the game state machine (00 none, 01 left, 10 mid, 11 right)
//   PLAYER_LANE [1:0], PLAYER_JUMP: player position and airborne flag
//   LIVES, SCORE, ZERO_LIVES, HIT_FLASH: player status back to the state machine and renderer
//   BARRIER_*/COIN_*: falling object slots for the renderer
interface life_compositor_if;
  logic [1:0] RELEASE_BARRIER;
  logic [1:0] RELEASE_COIN;
  logic [1:0] PLAYER_LANE;
  logic       PLAYER_JUMP;
  logic [1:0] LIVES;
  logic [7:0] SCORE;
  logic       ZERO_LIVES;
  logic       BARRIER_ACTIVE;
  logic [1:0] BARRIER_LANE;
  logic [9:0] BARRIER_Y;
  logic       COIN_ACTIVE;
  logic [1:0] COIN_LANE;
  logic [9:0] COIN_Y;
  logic       HIT_FLASH;

  // Game logic side drives the release and player signals, and reads the status.
  modport master (
    output RELEASE_BARRIER, RELEASE_COIN, PLAYER_LANE, PLAYER_JUMP,
    input  LIVES, SCORE, ZERO_LIVES, BARRIER_ACTIVE, BARRIER_LANE, BARRIER_Y,
           COIN_ACTIVE, COIN_LANE, COIN_Y, HIT_FLASH
  );

  // The compositor reads the release and player signals, and drives the status.
  modport slave (
    input  RELEASE_BARRIER, RELEASE_COIN, PLAYER_LANE, PLAYER_JUMP,
    output LIVES, SCORE, ZERO_LIVES, BARRIER_ACTIVE, BARRIER_LANE, BARRIER_Y,
           COIN_ACTIVE, COIN_LANE, COIN_Y, HIT_FLASH
  );
endinterface

// File: rtl/life_compositor.sv
// Falling barrier/coin slots with collision, lives/score bookkeeping and an ALIVE/INVULN/DEAD FSM.
// Latency: every output is registered and reflects the inputs sampled at the previous v_sync edge.
// Backpressure: none. One update happens per frame, and releases are edge-detected against their previous value.
// Ports: i_v_sync (frame clock), i_rst_n (sync active-low reset), bus (life_compositor_if.slave).
module life_compositor #(
  parameter int START_LIVES   = 3,
  parameter int SPEED         = 4,
  parameter int HIT_Y_MIN     = 400,
  parameter int HIT_Y_MAX     = 440,
  parameter int SCREEN_H      = 480,
  parameter int INVULN_FRAMES = 60,
  parameter int COIN_VALUE    = 10
) (
  input  logic             i_v_sync,
  input  logic             i_rst_n,
  life_compositor_if.slave bus
);
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  localparam logic [9:0]  L_HIT_MIN  = 10'(HIT_Y_MIN);
  localparam logic [9:0]  L_HIT_MAX  = 10'(HIT_Y_MAX);
  localparam logic [10:0] L_SPEED    = 11'(SPEED);
  localparam logic [10:0] L_SCREEN_H = 11'(SCREEN_H);
  localparam logic [8:0]  L_COIN     = 9'(COIN_VALUE);
  localparam logic [15:0] L_INV_LOAD = 16'(INVULN_FRAMES - 1);
  localparam logic [1:0]  L_LIVES0   = 2'(START_LIVES);

  state_t      r_state;
  logic [15:0] r_inv_cnt;
  logic [1:0]  r_lives;
  logic [7:0]  r_score;
  logic        r_zero;
  logic        r_flash;
  logic        r_bar_act;
  logic [1:0]  r_bar_lane;
  logic [9:0]  r_bar_y;
  logic        r_coin_act;
  logic [1:0]  r_coin_lane;
  logic [9:0]  r_coin_y;
  logic [1:0]  r_prev_bar;
  logic [1:0]  r_prev_coin;

  logic        w_bar_spawn;
  logic        w_coin_spawn;
  logic        w_bar_in_win;
  logic        w_coin_in_win;
  logic        w_bar_hit;
  logic        w_coin_hit;
  logic [10:0] w_bar_sum;
  logic [10:0] w_coin_sum;
  logic [8:0]  w_score_sum;

  always_comb begin
    // A spawn needs a new non-zero code. A held code or a return to 00 leaves the slot alone.
    w_bar_spawn   = (bus.RELEASE_BARRIER != 2'b00) && (bus.RELEASE_BARRIER != r_prev_bar);
    w_coin_spawn  = (bus.RELEASE_COIN != 2'b00) && (bus.RELEASE_COIN != r_prev_coin);
    // Collision uses the y value from before this frame's advance.
    w_bar_in_win  = r_bar_act && (r_bar_y >= L_HIT_MIN) && (r_bar_y <= L_HIT_MAX)
                    && (r_bar_lane == bus.PLAYER_LANE);
    w_coin_in_win = r_coin_act && (r_coin_y >= L_HIT_MIN) && (r_coin_y <= L_HIT_MAX)
                    && (r_coin_lane == bus.PLAYER_LANE);
    // A barrier only does damage to a grounded player in ALIVE. Otherwise it keeps falling.
    w_bar_hit     = !w_bar_spawn && w_bar_in_win && !bus.PLAYER_JUMP && (r_state == ALIVE);
    w_coin_hit    = !w_coin_spawn && w_coin_in_win;
    // One extra bit so the despawn compare cannot wrap.
    w_bar_sum     = {1'b0, r_bar_y} + L_SPEED;
    w_coin_sum    = {1'b0, r_coin_y} + L_SPEED;
    w_score_sum   = {1'b0, r_score} + L_COIN;
  end

  always_ff @(posedge i_v_sync) begin
    if (!i_rst_n) begin
      r_state     <= ALIVE;
      r_inv_cnt   <= 16'd0;
      r_lives     <= L_LIVES0;
      r_score     <= 8'd0;
      r_zero      <= 1'b0;
      r_flash     <= 1'b0;
      r_bar_act   <= 1'b0;
      r_bar_lane  <= 2'b00;
      r_bar_y     <= 10'd0;
      r_coin_act  <= 1'b0;
      r_coin_lane <= 2'b00;
      r_coin_y    <= 10'd0;
      r_prev_bar  <= 2'b00;
      r_prev_coin <= 2'b00;
    end else begin
      r_prev_bar  <= bus.RELEASE_BARRIER;
      r_prev_coin <= bus.RELEASE_COIN;
      if (r_state == DEAD) begin
        // Game over: the playfield stays empty, and score and lives are frozen.
        r_bar_act   <= 1'b0;
        r_bar_lane  <= 2'b00;
        r_bar_y     <= 10'd0;
        r_coin_act  <= 1'b0;
        r_coin_lane <= 2'b00;
        r_coin_y    <= 10'd0;
      end else begin
        if (w_bar_spawn) begin
          r_bar_act  <= 1'b1;
          r_bar_lane <= bus.RELEASE_BARRIER;
          r_bar_y    <= 10'd0;
        end else if (w_bar_hit) begin
          r_bar_act  <= 1'b0;
          r_bar_lane <= 2'b00;
          r_bar_y    <= 10'd0;
        end else if (r_bar_act) begin
          if (w_bar_sum >= L_SCREEN_H) begin
            r_bar_act <= 1'b0;
            r_bar_y   <= 10'd0;
          end else begin
            r_bar_y <= w_bar_sum[9:0];
          end
        end

        if (w_coin_spawn) begin
          r_coin_act  <= 1'b1;
          r_coin_lane <= bus.RELEASE_COIN;
          r_coin_y    <= 10'd0;
        end else if (w_coin_hit) begin
          r_coin_act  <= 1'b0;
          r_coin_lane <= 2'b00;
          r_coin_y    <= 10'd0;
          r_score     <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
        end else if (r_coin_act) begin
          if (w_coin_sum >= L_SCREEN_H) begin
            r_coin_act <= 1'b0;
            r_coin_y   <= 10'd0;
          end else begin
            r_coin_y <= w_coin_sum[9:0];
          end
        end

        case (r_state)
          ALIVE: begin
            if (w_bar_hit) begin
              r_lives <= r_lives - 2'd1;
              if (r_lives == 2'd1) begin
                r_state <= DEAD;
                r_zero  <= 1'b1;
              end else begin
                r_state   <= INVULN;
                r_flash   <= 1'b1;
                r_inv_cnt <= L_INV_LOAD;
              end
            end
          end
          INVULN: begin
            if (r_inv_cnt == 16'd0) begin
              r_state <= ALIVE;
              r_flash <= 1'b0;
            end else begin
              r_inv_cnt <= r_inv_cnt - 16'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.LIVES          = r_lives;
  assign bus.SCORE          = r_score;
  assign bus.ZERO_LIVES     = r_zero;
  assign bus.HIT_FLASH      = r_flash;
  assign bus.BARRIER_ACTIVE = r_bar_act;
  assign bus.BARRIER_LANE   = r_bar_lane;
  assign bus.BARRIER_Y      = r_bar_y;
  assign bus.COIN_ACTIVE    = r_coin_act;
  assign bus.COIN_LANE      = r_coin_lane;
  assign bus.COIN_Y         = r_coin_y;
endmodule

// File: tb/tb_life_compositor.sv
// Bench for life_compositor. It runs directed game scenarios, then random play.
// Every frame is checked against a frame-level game model.
// A second instance with a longer immunity window shows a barrier passing through during INVULN.
module tb_life_compositor;
  localparam int M_ALIVE = 0;
  localparam int M_INV   = 1;
  localparam int M_DEAD  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  life_compositor_if bif();
  life_compositor_if bif2();

  assign bif2.RELEASE_BARRIER = bif.RELEASE_BARRIER;
  assign bif2.RELEASE_COIN    = bif.RELEASE_COIN;
  assign bif2.PLAYER_LANE     = bif.PLAYER_LANE;
  assign bif2.PLAYER_JUMP     = bif.PLAYER_JUMP;

  life_compositor dut (.i_v_sync(clk), .i_rst_n(rst_n), .bus(bif));
  life_compositor #(.INVULN_FRAMES(150)) dut_long (.i_v_sync(clk), .i_rst_n(rst_n), .bus(bif2));

  int n_vec = 0;
  int n_err = 0;

  // Game model. Positions are in pixels, and m_left counts the frames of immunity still owed.
  int m_lives, m_score, m_mode, m_left;
  int m_bact, m_blane, m_by, m_cact, m_clane, m_cy, m_pb, m_pc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int rb, input int rc, input int lane, input int jump);
    bif.RELEASE_BARRIER = 2'(rb);
    bif.RELEASE_COIN    = 2'(rc);
    bif.PLAYER_LANE     = 2'(lane);
    bif.PLAYER_JUMP     = 1'(jump);
  endtask

  function automatic bit in_window(input int y);
    return (y >= 400) && (y <= 440);
  endfunction

  task automatic model_step();
    int rb, rc, pl, jp;
    bit lost;
    rb = int'(bif.RELEASE_BARRIER);
    rc = int'(bif.RELEASE_COIN);
    pl = int'(bif.PLAYER_LANE);
    jp = int'(bif.PLAYER_JUMP);
    lost = 0;
    if (rst_n !== 1'b1) begin
      m_lives = 3; m_score = 0; m_mode = M_ALIVE; m_left = 0;
      m_bact = 0; m_blane = 0; m_by = 0; m_cact = 0; m_clane = 0; m_cy = 0;
      m_pb = 0; m_pc = 0;
    end else begin
      if (m_mode == M_DEAD) begin
        m_bact = 0; m_blane = 0; m_by = 0; m_cact = 0; m_clane = 0; m_cy = 0;
      end else begin
        if (rb != 0 && rb != m_pb) begin
          m_bact = 1; m_blane = rb; m_by = 0;
        end else if (m_bact == 1) begin
          if (in_window(m_by) && m_blane == pl && jp == 0 && m_mode == M_ALIVE) begin
            m_bact = 0; m_blane = 0; m_by = 0; lost = 1;
          end else begin
            m_by = m_by + 4;
            if (m_by >= 480) begin m_bact = 0; m_by = 0; end
          end
        end
        if (rc != 0 && rc != m_pc) begin
          m_cact = 1; m_clane = rc; m_cy = 0;
        end else if (m_cact == 1) begin
          if (in_window(m_cy) && m_clane == pl) begin
            m_cact = 0; m_clane = 0; m_cy = 0;
            m_score = (m_score + 10 > 255) ? 255 : m_score + 10;
          end else begin
            m_cy = m_cy + 4;
            if (m_cy >= 480) begin m_cact = 0; m_cy = 0; end
          end
        end
        if (lost) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_mode = M_DEAD;
          else begin m_mode = M_INV; m_left = 60; end
        end else if (m_mode == M_INV) begin
          // This frame uses up one of the remaining immune frames.
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_ALIVE;
        end
      end
      m_pb = rb; m_pc = rc;
    end
  endtask

  task automatic chk_all();
    chk("m_lives", 16'(bif.LIVES), 16'(m_lives));
    chk("m_score", 16'(bif.SCORE), 16'(m_score));
    chk("m_zero", 16'(bif.ZERO_LIVES), 16'(m_mode == M_DEAD));
    chk("m_flash", 16'(bif.HIT_FLASH), 16'(m_mode == M_INV));
    chk("m_bact", 16'(bif.BARRIER_ACTIVE), 16'(m_bact));
    chk("m_blane", 16'(bif.BARRIER_LANE), 16'(m_blane));
    chk("m_by", 16'(bif.BARRIER_Y), 16'(m_by));
    chk("m_cact", 16'(bif.COIN_ACTIVE), 16'(m_cact));
    chk("m_clane", 16'(bif.COIN_LANE), 16'(m_clane));
    chk("m_cy", 16'(bif.COIN_Y), 16'(m_cy));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_lives", 16'(bif.LIVES), 16'd3);
    chk("rst_score", 16'(bif.SCORE), 16'd0);
    chk("rst_zero", 16'(bif.ZERO_LIVES), 16'd0);
    chk("rst_flash", 16'(bif.HIT_FLASH), 16'd0);
    chk("rst_bact", 16'(bif.BARRIER_ACTIVE), 16'd0);
    rst_n = 1'b1;

    // Barrier in mid lane, player in left lane: it falls 4 px per frame and leaves on the 120th advance.
    set_in(2, 0, 1, 0);
    tick();
    chk("fall_spawn", 16'(bif.BARRIER_ACTIVE), 16'd1);
    set_in(0, 0, 1, 0);
    for (int n = 1; n <= 119; n++) begin
      tick();
      chk("fall_y", 16'(bif.BARRIER_Y), 16'(4 * n));
    end
    tick();
    chk("despawn_act", 16'(bif.BARRIER_ACTIVE), 16'd0);
    chk("despawn_y", 16'(bif.BARRIER_Y), 16'd0);
    chk("despawn_lives", 16'(bif.LIVES), 16'd3);

    // Barrier and player both in mid lane, player on the ground: the barrier hits at y=400.
    set_in(2, 0, 2, 0);
    tick();
    set_in(0, 0, 2, 0);
    repeat (100) tick();
    chk("pre_hit_y", 16'(bif.BARRIER_Y), 16'd400);
    tick();
    chk("hit_lives", 16'(bif.LIVES), 16'd2);
    chk("hit_flash", 16'(bif.HIT_FLASH), 16'd1);
    chk("hit_bact", 16'(bif.BARRIER_ACTIVE), 16'd0);
    set_in(2, 0, 2, 0);
    tick();
    chk("flash_hold", 16'(bif.HIT_FLASH), 16'd1);
    set_in(0, 0, 2, 0);
    for (int i = 2; i <= 59; i++) begin
      tick();
      chk("flash_hold", 16'(bif.HIT_FLASH), 16'd1);
    end
    tick();
    chk("flash_end", 16'(bif.HIT_FLASH), 16'd0);
    repeat (41) tick();
    chk("b2_y", 16'(bif.BARRIER_Y), 16'd400);
    chk("long_b2_y", 16'(bif2.BARRIER_Y), 16'd400);
    tick();
    chk("b2_lives_alive", 16'(bif.LIVES), 16'd1);
    chk("long_inv_lives", 16'(bif2.LIVES), 16'd2);
    chk("long_inv_flash", 16'(bif2.HIT_FLASH), 16'd1);
    chk("long_inv_bact", 16'(bif2.BARRIER_ACTIVE), 16'd1);
    chk("long_inv_by", 16'(bif2.BARRIER_Y), 16'd404);

    // Coins in right lane with the player airborne: each coin adds 10, and the score saturates at 255.
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      set_in(0, 3, 3, 1);
      tick();
      set_in(0, 0, 3, 1);
      repeat (100) tick();
      tick();
      chk("coin_score", 16'(bif.SCORE), 16'((10 * k > 255) ? 255 : 10 * k));
      chk("coin_clear", 16'(bif.COIN_ACTIVE), 16'd0);
    end

    // Three grounded barrier hits, more than 60 frames apart, end the game.
    do_reset();
    for (int h = 1; h <= 3; h++) begin
      set_in(2, 0, 2, 0);
      tick();
      set_in(0, 0, 2, 0);
      repeat (100) tick();
      tick();
      chk("dead_lives", 16'(bif.LIVES), 16'(3 - h));
      chk("dead_zero", 16'(bif.ZERO_LIVES), 16'(h == 3));
    end
    set_in(1, 2, 2, 0);
    tick();
    tick();
    chk("dead_nospawn_b", 16'(bif.BARRIER_ACTIVE), 16'd0);
    chk("dead_nospawn_c", 16'(bif.COIN_ACTIVE), 16'd0);
    set_in(3, 1, 2, 0);
    tick();
    chk("dead_nospawn_b2", 16'(bif.BARRIER_ACTIVE), 16'd0);
    chk("dead_frozen", 16'(bif.LIVES), 16'd0);

    // A coin and a barrier hit on the same frame: the score goes up and a life is lost.
    do_reset();
    set_in(2, 2, 2, 0);
    tick();
    set_in(0, 0, 2, 0);
    repeat (100) tick();
    tick();
    chk("both_score", 16'(bif.SCORE), 16'd10);
    chk("both_lives", 16'(bif.LIVES), 16'd2);
    chk("both_flash", 16'(bif.HIT_FLASH), 16'd1);

    // Reset during INVULN while a barrier is at y=200.
    set_in(2, 0, 2, 0);
    tick();
    set_in(0, 0, 2, 0);
    repeat (50) tick();
    chk("inv_by", 16'(bif.BARRIER_Y), 16'd200);
    chk("inv_flash", 16'(bif.HIT_FLASH), 16'd1);
    do_reset();
    chk("mid_rst_lives", 16'(bif.LIVES), 16'd3);
    chk("mid_rst_flash", 16'(bif.HIT_FLASH), 16'd0);
    chk("mid_rst_bact", 16'(bif.BARRIER_ACTIVE), 16'd0);

    // A release code held through reset spawns on the first frame after reset.
    set_in(1, 3, 0, 0);
    do_reset();
    tick();
    chk("held_bact", 16'(bif.BARRIER_ACTIVE), 16'd1);
    chk("held_blane", 16'(bif.BARRIER_LANE), 16'd1);
    chk("held_cact", 16'(bif.COIN_ACTIVE), 16'd1);

    // Random play, checked against the model every frame.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) bif.RELEASE_BARRIER = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) bif.RELEASE_COIN = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) bif.PLAYER_LANE = 2'($urandom_range(3));
      bif.PLAYER_JUMP = ($urandom_range(3) == 0);
      rst_n = ($urandom_range(799) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
